// File: rtl/sha_pad_stream_if.sv
// sha_pad_stream_if -- byte-stream input and padded-block output bundle for
// sha_pad_stream.
//   in_data/in_valid/in_last/in_empty/in_ready : byte stream, one byte per beat
//   blk_data/blk_valid/blk_ready/blk_first/blk_last : 16*NW-bit message blocks
//   blk_idx : block index within the message (only with SHA_PAD_BLKCNT_EN)
// Modports: slave = the padder, master = byte source / block consumer side.
interface sha_pad_stream_if #(
  parameter int NW = 32
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_empty;
  logic             in_ready;
  logic [16*NW-1:0] blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic             blk_first;
  logic             blk_last;
`ifdef SHA_PAD_BLKCNT_EN
  logic [15:0]      blk_idx;
`endif

  modport slave (
    input  in_data, in_valid, in_last, in_empty, blk_ready,
`ifdef SHA_PAD_BLKCNT_EN
    output blk_idx,
`endif
    output in_ready, blk_data, blk_valid, blk_first, blk_last
  );

  modport master (
    output in_data, in_valid, in_last, in_empty, blk_ready,
`ifdef SHA_PAD_BLKCNT_EN
    input  blk_idx,
`endif
    input  in_ready, blk_data, blk_valid, blk_first, blk_last
  );
endinterface

// File: rtl/sha_pad_stream.sv
// sha_pad_stream -- streaming SHA message padder (FIPS 180-4 padding).
// Accepts one byte per cycle and emits 16-word blocks with the 0x80 marker,
// zero fill and big-endian bit-length field, adding an extra block when the
// length does not fit behind the last message byte.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-low reset
//   bus  : sha_pad_stream_if.slave (byte stream in, block stream out)
// Parameter NW: word width, 32 (SHA-256 class) or 64 (SHA-512 class).
// Optional macro SHA_PAD_BLKCNT_EN adds bus.blk_idx, the per-message block index.
module sha_pad_stream #(
  parameter int NW = 32
) (
  input  logic              clk,
  input  logic              rst,
  sha_pad_stream_if.slave   bus
);

  localparam int NB   = 2 * NW;          // block bytes
  localparam int NL   = NW / 4;          // length-field bytes
  localparam int BITS = 16 * NW;         // block bits
  localparam int BW   = 2 * NW;          // bit-length counter width
  localparam int CW   = $clog2(NB + 1);  // cnt range 0..NB
  localparam int IW   = $clog2(NB);      // byte index within block

  localparam logic [CW-1:0] CNT_LAST    = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_LEN_MAX = CW'(NB - NL - 1);

  typedef enum logic [1:0] {FILL, PAD, EXTRA, EMIT} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] blk_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bitlen_q;
  logic            first_q;
  logic            pend_pad_q;
  logic            pad_done_q;
  logic            final_q;

  logic            accept;
  logic            take_byte;
  logic [IW-1:0]   wr_idx;
  logic [IW+2:0]   wr_lsb;

  // Byte k sits at bit 8*(NB-1-k); NB is a power of two, so NB-1-k == ~k.
  always_comb begin
    accept    = (state_q == FILL) && bus.in_valid;
    take_byte = accept && !bus.in_empty;
    wr_idx    = cnt_q[IW-1:0];
    wr_lsb    = {~wr_idx, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = (state_q == FILL);
    bus.blk_valid = (state_q == EMIT);
    // first_q is armed during reset so the first message is tagged, but the
    // visible flags only assert alongside blk_valid.
    bus.blk_first = first_q && (state_q == EMIT);
    bus.blk_last  = final_q && (state_q == EMIT);
    bus.blk_data  = blk_q;
    case (state_q)
      FILL: begin
        if (take_byte) begin
          if (cnt_q == CNT_LAST)  state_d = EMIT;
          else if (bus.in_last)   state_d = PAD;
        end else if (accept && bus.in_last) begin
          state_d = PAD;
        end
      end
      PAD:   state_d = EMIT;
      EXTRA: state_d = EMIT;
      EMIT: begin
        if (bus.blk_ready) begin
          if (final_q)         state_d = FILL;
          else if (pend_pad_q) state_d = PAD;
          else if (pad_done_q) state_d = EXTRA;
          else                 state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_q      <= '0;
      cnt_q      <= '0;
      bitlen_q   <= '0;
      first_q    <= 1'b1;
      pend_pad_q <= 1'b0;
      pad_done_q <= 1'b0;
      final_q    <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (take_byte) begin
            blk_q[wr_lsb +: 8] <= bus.in_data;
            cnt_q              <= cnt_q + 1'b1;
            bitlen_q           <= bitlen_q + BW'(8);
            if (cnt_q == CNT_LAST) pend_pad_q <= bus.in_last;
          end
        end
        PAD: begin
          blk_q[wr_lsb +: 8] <= 8'h80;
          if (cnt_q <= CNT_LEN_MAX) begin
            blk_q[BW-1:0] <= bitlen_q;
            final_q       <= 1'b1;
          end else begin
            pad_done_q <= 1'b1;
          end
        end
        EXTRA: begin
          blk_q   <= BITS'(bitlen_q);
          final_q <= 1'b1;
        end
        EMIT: begin
          if (bus.blk_ready) begin
            blk_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            if (final_q) begin
              bitlen_q   <= '0;
              final_q    <= 1'b0;
              pend_pad_q <= 1'b0;
              pad_done_q <= 1'b0;
              first_q    <= 1'b1;
            end else if (pend_pad_q) begin
              pend_pad_q <= 1'b0;
            end else if (pad_done_q) begin
              pad_done_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA_PAD_BLKCNT_EN
  logic [15:0] idx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
    end else if (state_q == EMIT && bus.blk_ready) begin
      idx_q <= final_q ? 16'd0 : idx_q + 16'd1;
    end
  end

  assign bus.blk_idx = idx_q;
`endif

endmodule
